// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode constants: reset vector, fetch timeout,
// fetch FSM encoding and opcodes used by the control decoder.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [7:0]  TIMEOUT      = 8'd255;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  function automatic logic [31:0] br_off(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next fetch address: jump beats taken branch beats
// sequential; all arithmetic wraps at 32 bits.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mux_branch_jump,
  output logic [31:0] next_pc
);

  logic unused_op;
  assign unused_op = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (!mux_branch_jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + br_off(instr[15:0]);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request/ack to imem, hold the word
// until downstream accepts, then steer to the next PC.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        branch_taken,
  input  logic        mux_branch_jump,
  output logic        fetch_err
);

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] next_pc;
  logic [7:0]  cnt;

  next_pc_calc u_npc (
    .pc_plus4        (pc_plus4),
    .instr           (instr_q),
    .branch_taken    (branch_taken),
    .mux_branch_jump (mux_branch_jump),
    .next_pc         (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_VECTOR;
      pc_q     <= 32'h0;
      instr_q  <= 32'h0;
      cnt      <= 8'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state <= S_REQ;
          cnt   <= 8'h0;
        end
        S_REQ: begin
          // ack on the last allowed cycle still wins
          if (imem_ack) begin
            instr_q <= imem_rdata;
            pc_q    <= fetch_pc;
            state   <= S_HOLD;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == TIMEOUT - 8'd1)
              state <= S_ERR;
          end
        end
        S_HOLD: begin
          if (instr_accept) begin
            fetch_pc <= next_pc;
            cnt      <= 8'h0;
            state    <= S_REQ;
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = imem_req ? fetch_pc : 32'h0;
  assign instr_valid = (state == S_HOLD);
  assign instr       = instr_valid ? instr_q : 32'h0;
  assign opcode      = instr[31:26];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_err   = (state == S_ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for
// next-PC steering plus timeout/stall/reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_accept = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mux_branch_jump = 1'b1;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .opcode          (opcode),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .instr_valid     (instr_valid),
    .instr_accept    (instr_accept),
    .branch_taken    (branch_taken),
    .mux_branch_jump (mux_branch_jump),
    .fetch_err       (fetch_err)
  );

  typedef struct {
    logic [31:0] rdata;
    int          dly;
    logic        mj;
    logic        bt;
    logic [31:0] exp_pc;
    logic [5:0]  exp_op;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_req: got no imem_req expected 1 within 20 cycles");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    instr_accept = 1'b0;
    branch_taken = 1'b0;
    mux_branch_jump = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // fetch one word and park in HOLD
  task automatic fetch_word(input logic [31:0] exp_addr,
                            input logic [31:0] rd,
                            input int dly);
    bit ok;
    wait_req(ok);
    if (ok) begin
      chk("req_addr", imem_addr, exp_addr);
      repeat (dly) @(negedge clk);
      imem_ack = 1'b1;
      imem_rdata = rd;
      @(negedge clk);
      imem_ack = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    fetch_word(v.exp_pc, v.rdata, v.dly);
    chk("vec_valid", 32'(instr_valid), 32'd1);
    chk("vec_opcode", 32'(opcode), 32'(v.exp_op));
    chk("vec_pc", pc, v.exp_pc);
    chk("vec_instr", instr, v.rdata);
    instr_accept = 1'b1;
    mux_branch_jump = v.mj;
    branch_taken = v.bt;
    @(negedge clk);
    instr_accept = 1'b0;
    mux_branch_jump = 1'b1;
    branch_taken = 1'b0;
    chk("vec_req", 32'(imem_req), 32'd1);
    chk("vec_next", imem_addr, v.exp_next);
  endtask

  initial begin
    vecs[0] = '{32'h20080005, 2, 1'b1, 1'b0, 32'h0,     6'b001000, 32'h4};
    vecs[1] = '{32'h08000010, 0, 1'b0, 1'b0, 32'h4,     6'b000010, 32'h40};
    vecs[2] = '{32'h08000010, 1, 1'b0, 1'b0, 32'h40,    6'b000010, 32'h40};
    vecs[3] = '{32'h08000040, 0, 1'b0, 1'b1, 32'h40,    6'b000010, 32'h100};
    vecs[4] = '{32'h1000FFFE, 0, 1'b1, 1'b1, 32'h100,   6'b000100, 32'hFC};
    vecs[5] = '{32'h08000040, 3, 1'b0, 1'b0, 32'hFC,    6'b000010, 32'h100};
    vecs[6] = '{32'h1000FFFE, 0, 1'b1, 1'b0, 32'h100,   6'b000100, 32'h104};
    vecs[7] = '{32'h1000FFFE, 0, 1'b0, 1'b1, 32'h104,   6'b000100, 32'h003FFF8};
    vecs[8] = '{32'h00000000, 0, 1'b1, 1'b1, 32'h3FFF8, 6'b000000, 32'h3FFFC};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_err", 32'(fetch_err), 32'd0);
    rst = 1'b0;
    // IDLE for one cycle, then REQ
    chk("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("req_rise", 32'(imem_req), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // wrap and stall at top of address space
    do_reset();
    fetch_word(32'h0, 32'h1000FFFE, 0);
    instr_accept = 1'b1;
    branch_taken = 1'b1;
    @(negedge clk);
    instr_accept = 1'b0;
    branch_taken = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
    fetch_word(32'hFFFFFFFC, 32'h1000FFFE, 0);
    for (int i = 0; i < 10; i++) begin
      imem_ack = i[0];
      imem_rdata = 32'hDEADBEEF;
      branch_taken = ~i[0];
      mux_branch_jump = i[1];
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, 32'h1000FFFE);
      chk("stall_pc", pc, 32'hFFFFFFFC);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
    chk("wrap_pc4", pc_plus4, 32'h0);
    instr_accept = 1'b1;
    mux_branch_jump = 1'b1;
    branch_taken = 1'b0;
    @(negedge clk);
    instr_accept = 1'b0;
    chk("wrap_next", imem_addr, 32'h0);

    // timeout: 255 REQ cycles with no ack
    do_reset();
    begin
      bit ok;
      wait_req(ok);
    end
    repeat (254) @(negedge clk);
    chk("to_last_req", 32'(imem_req), 32'd1);
    chk("to_last_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_req", 32'(imem_req), 32'd0);
    chk("to_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1;
    instr_accept = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    instr_accept = 1'b0;
    chk("to_sticky", 32'(fetch_err), 32'd1);
    chk("to_sticky_req", 32'(imem_req), 32'd0);

    // ack on the 255th REQ cycle wins
    do_reset();
    fetch_word(32'h0, 32'h20080005, 254);
    chk("ack255_valid", 32'(instr_valid), 32'd1);
    chk("ack255_err", 32'(fetch_err), 32'd0);
    chk("ack255_instr", instr, 32'h20080005);

    // reset while holding; stray ack in IDLE
    rst = 1'b1;
    @(negedge clk);
    chk("hrst_valid", 32'(instr_valid), 32'd0);
    chk("hrst_opcode", 32'(opcode), 32'd0);
    chk("hrst_pc", pc, 32'h0);
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("stray_valid", 32'(instr_valid), 32'd0);
    chk("stray_req", 32'(imem_req), 32'd1);
    fetch_word(32'h0, 32'h08000010, 1);
    chk("post_instr", instr, 32'h08000010);
    chk("post_opcode", 32'(opcode), 32'(6'b000010));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high; ports are named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 imem_req  out  1  instruction-memory read request, held until acknowledged.
REQ-005 imem_addr  out  32  word-aligned fetch address; bits [1:0] always 00.
REQ-006 imem_ack  in  1  one-cycle pulse: imem_rdata valid this cycle.
REQ-007 imem_rdata  in  32  instruction word returned by memory.
REQ-008 instr  out  32  held instruction word; 32'h00000000 (nop) when instr_valid=0.
REQ-009 opcode  out  6  instr[31:26], fed to the control decoder; 6'b000000 when instr_valid=0.
REQ-010 pc  out  32  address of the held instruction.
REQ-011 pc_plus4  out  32  pc + 4, modulo 2^32.
REQ-012 instr_valid  out  1  instr/opcode/pc are valid and held.
REQ-013 instr_accept  in  1  downstream retires the held instruction this cycle; ignored when instr_valid=0.
REQ-014 branch_taken  in  1  resolved branch outcome (branch AND condition), sampled only with instr_accept.
REQ-015 mux_branch_jump  in  1  0 = jump, 1 = branch/sequential (control-unit polarity), sampled only with instr_accept.
REQ-016 fetch_err  out  1  sticky: memory did not acknowledge within TIMEOUT cycles.

Function
REQ-017 FSM states: IDLE, REQ, HOLD, ERR.
REQ-018 IDLE: all outputs inactive; next cycle -> REQ.
REQ-019 REQ: imem_req=1, imem_addr=fetch PC; on imem_ack, latch imem_rdata into instr, latch address into pc, -> HOLD.
REQ-020 HOLD: instr_valid=1, imem_req=0; outputs stable until instr_accept=1, then load next PC and -> REQ.
REQ-021 Latency: instr_valid rises the cycle after imem_ack; imem_req rises the cycle after instr_accept.
REQ-022 Next PC priority: mux_branch_jump=0 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch_taken=1 -> pc_plus4 + (sign_ext(instr[15:0]) << 2); else pc_plus4.
REQ-023 All PC arithmetic SHALL be 32-bit and wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-024 Timeout counter (8 bits) clears on entry to REQ and increments each REQ cycle without imem_ack; reaching TIMEOUT=255 -> ERR.
REQ-025 imem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: instruction accepted, no error.
REQ-026 ERR: fetch_err=1, imem_req=0, instr_valid=0; leaves only by rst.
REQ-027 imem_ack outside REQ SHALL be ignored.
REQ-028 instr_accept outside HOLD SHALL be ignored; branch_taken/mux_branch_jump have no effect without instr_accept in HOLD.

Reset
REQ-029 On rst=1: state=IDLE, fetch PC=RESET_VECTOR (32'h00000000), pc=0, instr=0, instr_valid=0, imem_req=0, imem_addr=0, fetch_err=0, counter=0.
REQ-030 rst mid-operation (REQ or HOLD) SHALL abandon the transaction; a later imem_ack for it is ignored per REQ-027.

Structure
REQ-031 Shared package SHALL hold RESET_VECTOR, TIMEOUT, FSM state encoding and the opcode constants shared with the control decoder.
REQ-032 Next-PC computation SHALL be a combinational sub-module named next_pc_calc (inputs pc_plus4, instr, branch_taken, mux_branch_jump; output next_pc).

Verification
REQ-033 Reset then ack after 2 cycles with rdata=0x20080005 -> imem_addr=0x0, instr_valid next cycle, opcode=6'b001000, pc=0; accept -> next imem_addr=0x4.
REQ-034 Jump: held instr=0x08000010 at pc=0x40, accept with mux_branch_jump=0 -> next imem_addr=0x00000040.
REQ-035 Branch: held instr=0x1000FFFE at pc=0x100, accept with branch_taken=1 -> next imem_addr=0x000000FC; branch_taken=0 -> 0x104.
REQ-036 Timeout: no ack for 255 REQ cycles -> fetch_err=1, imem_req=0; ack on cycle 255 -> no error, instr_valid=1.
REQ-037 Wrap/stall: pc=0xFFFFFFFC held 10 cycles without accept -> outputs stable; accept -> imem_addr=0x00000000.
REQ-038 rst asserted in HOLD -> next cycle instr_valid=0, opcode=0, pc=0; stray imem_ack in IDLE ignored.
